axi_read_burst_ctrl: RTL

Read-only AXI4 slave that turns AR bursts into single-port memory reads, arbitrated through a `grant_i`/`valid_o` request pair. It is the parametrised successor of the single-outstanding read controller. It adds FIXED, INCR and WRAP addressing and narrow-size address stepping. A credit-controlled read-data FIFO keeps memory reads running while RREADY is low, and illegal requests get SLVERR responses. It sits between the AXI read channels and one port of the dual-port memory wrapper.

---
 rtl/axi_read_burst_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_burst_ctrl.sv
// Read-only AXI4 slave: AR bursts become single-port memory reads behind a credit-gated R FIFO.
// Define AXI_RD_WRAP_EN to enable WRAP addressing (LEN 1/3/7/15); otherwise WRAP bursts get SLVERR.
module axi_read_burst_ctrl #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_RDATA_WIDTH   = 64,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH/8,
  parameter int MEM_ADDR_WIDTH     = 13,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
  input  logic [7:0]                    ARLEN_i,
  input  logic [2:0]                    ARSIZE_i,
  input  logic [1:0]                    ARBURST_i,
  input  logic                          ARLOCK_i,
  input  logic [3:0]                    ARCACHE_i,
  input  logic [2:0]                    ARPROT_i,
  input  logic [3:0]                    ARREGION_i,
  input  logic [3:0]                    ARQOS_i,
  input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
  input  logic                          ARVALID_i,
  output logic                          ARREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]      RID_o,
  output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
  output logic [1:0]                    RRESP_o,
  output logic                          RLAST_o,
  output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
  output logic                          RVALID_o,
  input  logic                          RREADY_i,
  output logic                          MEM_CEN_o,
  output logic                          MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
  output logic [AXI4_RDATA_WIDTH-1:0]   MEM_D_o,
  output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
  input  logic [AXI4_RDATA_WIDTH-1:0]   MEM_Q_i,
  input  logic                          grant_i,
  output logic                          valid_o
);
  localparam int OFFSET = $clog2(AXI_NUMBYTES);
  localparam int AW     = MEM_ADDR_WIDTH + OFFSET;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int SW     = CW + 1;
  localparam int DW     = AXI4_RDATA_WIDTH;
  localparam int IW     = AXI4_ID_WIDTH;
  localparam int UW     = AXI4_USER_WIDTH;
  localparam int EW     = DW + IW + UW + 3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BURST = 2'd1, S_ERR = 2'd2} state_t;

  // FIXED holds; INCR/WRAP align to the beat size before stepping, so only beat 0 is unaligned.
  function automatic logic [AW-1:0] f_step(input logic [AW-1:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst);
    logic [AW-1:0] inc;
    inc = AW'(1) << size;
    case (burst)
      2'b01, 2'b10: f_step = (addr & ~(inc - AW'(1))) + inc;
      default:      f_step = addr;
    endcase
  endfunction

`ifdef AXI_RD_WRAP_EN
  function automatic logic [AW-1:0] f_wrap(input logic [AW-1:0] addr, input logic [AW-1:0] nxt,
                                           input logic [7:0] len, input logic [2:0] size);
    logic [AW-1:0] mask;
    mask   = ((AW'(len) + AW'(1)) << size) - AW'(1);
    f_wrap = (addr & ~mask) | (nxt & mask);
  endfunction
`endif

  state_t r_state, w_next;
  logic [IW-1:0] r_id, r_pend_id;
  logic [UW-1:0] r_user, r_pend_user;
  logic [7:0] r_len, r_cnt;
  logic [2:0] r_size;
  logic [1:0] r_burst;
  logic [AW-1:0] r_addr;
  logic r_inflight, r_pend_last;
  logic [EW-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic w_empty, w_pop, w_push, w_credit, w_valid, w_arready, w_err_push, w_grant, w_hs;
  logic w_ar_illegal, w_wrap_bad;
  logic [MEM_ADDR_WIDTH-1:0] w_mem_a;
  logic [AW-1:0] w_ar_addr, w_ar_next, w_bu_next;
  logic [EW-1:0] w_push_data, w_head;
  logic w_unused_ok;

  assign w_unused_ok = ^{ARLOCK_i, ARCACHE_i, ARPROT_i, ARREGION_i, ARQOS_i,
                         ARADDR_i[AXI4_ADDRESS_WIDTH-1:AW]};
  assign w_ar_addr = ARADDR_i[AW-1:0];

`ifdef AXI_RD_WRAP_EN
  assign w_wrap_bad = (ARBURST_i == 2'b10) && !((ARLEN_i == 8'd1) || (ARLEN_i == 8'd3) ||
                                                (ARLEN_i == 8'd7) || (ARLEN_i == 8'd15));
  assign w_ar_next  = (ARBURST_i == 2'b10) ?
                      f_wrap(w_ar_addr, f_step(w_ar_addr, ARSIZE_i, ARBURST_i), ARLEN_i, ARSIZE_i) :
                      f_step(w_ar_addr, ARSIZE_i, ARBURST_i);
  assign w_bu_next  = (r_burst == 2'b10) ?
                      f_wrap(r_addr, f_step(r_addr, r_size, r_burst), r_len, r_size) :
                      f_step(r_addr, r_size, r_burst);
`else
  assign w_wrap_bad = (ARBURST_i == 2'b10);
  assign w_ar_next  = f_step(w_ar_addr, ARSIZE_i, ARBURST_i);
  assign w_bu_next  = f_step(r_addr, r_size, r_burst);
`endif

  assign w_ar_illegal = (ARSIZE_i > 3'(OFFSET)) || (ARBURST_i == 2'b11) || w_wrap_bad;
  assign w_empty  = (r_count == CW'(0));
  assign w_pop    = !w_empty && RREADY_i;
  // A pop frees a slot in the same cycle; the outstanding read already owns one.
  assign w_credit = (SW'(r_count) + SW'(r_inflight) - SW'(w_pop)) < SW'(FIFO_DEPTH);

  // Output decode: memory request, AR accept and error-beat push per state.
  always_comb begin
    w_valid    = 1'b0;
    w_arready  = 1'b0;
    w_err_push = 1'b0;
    w_mem_a    = {MEM_ADDR_WIDTH{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (ARVALID_i && !w_ar_illegal) begin
          w_valid   = w_credit;
          w_arready = w_credit && grant_i;
          w_mem_a   = w_credit ? w_ar_addr[AW-1:OFFSET] : {MEM_ADDR_WIDTH{1'b0}};
        end else if (ARVALID_i) begin
          w_arready = w_credit;
        end else begin
          w_arready = 1'b0;
        end
      end
      S_BURST: begin
        w_valid = w_credit;
        w_mem_a = r_addr[AW-1:OFFSET];
      end
      S_ERR:   w_err_push = w_credit && !r_inflight;
      default: w_valid = 1'b0;
    endcase
  end

  assign w_grant = w_valid && grant_i;
  assign w_hs    = ARVALID_i && w_arready;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs && w_ar_illegal)         w_next = S_ERR;
        else if (w_hs && ARLEN_i != 8'd0) w_next = S_BURST;
        else                              w_next = S_IDLE;
      end
      S_BURST: begin
        if (w_grant && r_cnt == r_len) w_next = S_IDLE;
        else                           w_next = S_BURST;
      end
      S_ERR: begin
        if (w_err_push && r_cnt == r_len) w_next = S_IDLE;
        else                              w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign w_push      = r_inflight || w_err_push;
  assign w_push_data = r_inflight ? {MEM_Q_i, r_pend_id, r_pend_user, r_pend_last, 2'b00} :
                                    {{DW{1'b0}}, r_id, r_user, (r_cnt == r_len), 2'b10};

  // Burst context, outstanding-read tag and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= {IW{1'b0}}; r_user <= {UW{1'b0}}; r_len <= 8'd0; r_cnt <= 8'd0;
      r_size <= 3'd0; r_burst <= 2'd0; r_addr <= {AW{1'b0}};
      r_inflight <= 1'b0; r_pend_id <= {IW{1'b0}}; r_pend_user <= {UW{1'b0}}; r_pend_last <= 1'b0;
      r_wptr <= {PW{1'b0}}; r_rptr <= {PW{1'b0}}; r_count <= {CW{1'b0}};
    end else begin
      if (r_state == S_IDLE && w_hs) begin
        r_id <= ARID_i; r_user <= ARUSER_i; r_len <= ARLEN_i;
        r_size <= ARSIZE_i; r_burst <= ARBURST_i; r_addr <= w_ar_next;
        r_cnt <= w_ar_illegal ? 8'd0 : 8'd1;
      end else if (r_state == S_BURST && w_grant) begin
        r_addr <= w_bu_next;
        r_cnt  <= r_cnt + 8'd1;
      end else if (w_err_push) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      r_inflight <= w_grant;
      if (w_grant) begin
        r_pend_id   <= (r_state == S_IDLE) ? ARID_i : r_id;
        r_pend_user <= (r_state == S_IDLE) ? ARUSER_i : r_user;
        r_pend_last <= (r_state == S_IDLE) ? (ARLEN_i == 8'd0) : (r_cnt == r_len);
      end
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage; contents are never observed while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_push_data;
  end

  assign w_head    = w_empty ? {EW{1'b0}} : r_fifo[r_rptr];
  assign RDATA_o   = w_head[EW-1 -: DW];
  assign RID_o     = w_head[3+UW +: IW];
  assign RUSER_o   = w_head[3 +: UW];
  assign RLAST_o   = w_head[2];
  assign RRESP_o   = w_head[1:0];
  assign RVALID_o  = !w_empty;
  assign ARREADY_o = w_arready;
  assign valid_o   = w_valid;
  assign MEM_CEN_o = ~w_valid;
  assign MEM_WEN_o = 1'b1;
  assign MEM_A_o   = w_mem_a;
  assign MEM_D_o   = {DW{1'b0}};
  assign MEM_BE_o  = {AXI_NUMBYTES{1'b0}};
endmodule
